// File: rtl/gray_pdm_fb.sv
// -----------------------------------------------------------------------------
// gray_pdm_fb
//
// Gray-weighted pulse-density modulator for a feedback path.
//
// Each enabled cycle, one bit of the active code is selected. The choice
// depends on which gray-counter bit would toggle on the next increment of the
// free-running binary frame counter. For a frame counter value cnt with k
// trailing ones:
//   - bit WIDTH-1-k of the code is selected when k < WIDTH;
//   - a 0 is output when cnt is all ones.
// Code bit j is therefore emitted 2^j times per 2^WIDTH-cycle frame, so a
// frame carries exactly `code` ones.
//
// Optional feature (macro GRAY_PDM_FRAME_SYNC_EN):
//   defined   - codes are buffered in a single-entry pending slot and only
//               applied at the frame-end edge, so no frame mixes two codes;
//               code_ready = !pend_full.
//   undefined - an accepted code is written straight to the active code;
//               code_ready is tied high and no pending slot is built.
//
// Parameters:
//   WIDTH        code width and frame-counter width (legal 2..16)
//
// Ports:
//   clk_ext      in   single clock, rising-edge
//   rst_ext      in   asynchronous active-high reset
//   en           in   advance frame counter; low freezes modulation
//   code_in      in   new code (unsigned, WIDTH bits)
//   code_valid   in   code_in offered
//   code_ready   out  code can be accepted (combinational)
//   pdm_out      out  registered modulated bitstream
//   frame_start  out  high while pdm_out carries bit 0 of a frame
// -----------------------------------------------------------------------------
module gray_pdm_fb #(
    parameter int WIDTH = 10
) (
    input  logic             clk_ext,
    input  logic             rst_ext,
    input  logic             en,
    input  logic [WIDTH-1:0] code_in,
    input  logic             code_valid,
    output logic             code_ready,
    output logic             pdm_out,
    output logic             frame_start
);

    // Width wide enough to hold a trailing-ones count of 0..WIDTH.
    localparam int KW = $clog2(WIDTH + 1);
    // Bit-reversed code is padded to a power of two so that every value of
    // the trailing-ones count indexes a real bit. Index WIDTH (all-ones
    // counter) lands on padding, which is zero.
    localparam int RW = 1 << KW;

    // Count of consecutive ones starting at bit 0. This equals the index of
    // the gray-code bit that toggles on the increment of v.
    function automatic logic [KW-1:0] trailing_ones(input logic [WIDTH-1:0] v);
        logic [KW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (run && v[i]) begin
                n = n + KW'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_code_act;
    logic             r_pdm;
    logic             r_frame_start;

    logic [KW-1:0]    w_k;
    logic [RW-1:0]    w_code_rev;
    logic             w_sel;
    logic             w_cnt_max;
    logic             w_frame_end;

    // Bit selection: reverse the active code so that trailing-ones count k
    // directly addresses code bit WIDTH-1-k.
    always_comb begin
        w_code_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_code_rev[i] = r_code_act[WIDTH-1-i];
        end
        w_k   = trailing_ones(r_cnt);
        w_sel = w_code_rev[w_k];
    end

    assign w_cnt_max   = &r_cnt;
    assign w_frame_end = en & w_cnt_max;

    // Frame counter and registered outputs; outputs reflect the counter
    // value sampled at the same edge, one cycle of latency.
    always_ff @(posedge clk_ext or posedge rst_ext) begin
        if (rst_ext) begin
            r_cnt         <= '0;
            r_pdm         <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_cnt         <= r_cnt + WIDTH'(1);
            r_pdm         <= w_sel;
            r_frame_start <= (r_cnt == '0);
        end else begin
            r_cnt         <= r_cnt;
            r_pdm         <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

`ifdef GRAY_PDM_FRAME_SYNC_EN
    logic [WIDTH-1:0] r_code_pend;
    logic             r_pend_full;
    logic             w_accept;

    assign code_ready = ~r_pend_full;
    assign w_accept   = code_valid & ~r_pend_full;

    // Code loading aligned to frame boundaries. A code accepted on the
    // frame-end edge bypasses the pending slot, which can only happen while
    // the slot is empty because code_ready is low otherwise.
    always_ff @(posedge clk_ext or posedge rst_ext) begin
        if (rst_ext) begin
            r_code_act  <= '0;
            r_code_pend <= '0;
            r_pend_full <= 1'b0;
        end else if (w_frame_end) begin
            if (w_accept) begin
                r_code_act  <= code_in;
                r_pend_full <= 1'b0;
            end else if (r_pend_full) begin
                r_code_act  <= r_code_pend;
                r_pend_full <= 1'b0;
            end else begin
                r_code_act  <= r_code_act;
                r_pend_full <= 1'b0;
            end
        end else if (w_accept) begin
            r_code_pend <= code_in;
            r_pend_full <= 1'b1;
        end else begin
            r_code_pend <= r_code_pend;
            r_pend_full <= r_pend_full;
        end
    end
`else
    assign code_ready = 1'b1;

    // Immediate code loading: the next selection already uses the new code,
    // so a frame in progress may mix two codes.
    always_ff @(posedge clk_ext or posedge rst_ext) begin
        if (rst_ext) begin
            r_code_act <= '0;
        end else if (code_valid) begin
            r_code_act <= code_in;
        end else begin
            r_code_act <= r_code_act;
        end
    end
`endif

    assign pdm_out     = r_pdm;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_gray_pdm_fb.sv
// -----------------------------------------------------------------------------
// tb_gray_pdm_fb
//
// Directed testbench for gray_pdm_fb. Instance u4 (WIDTH=4) covers reset,
// density, enable freeze and, with GRAY_PDM_FRAME_SYNC_EN, the frame-aligned
// handshake. Instance u10 (WIDTH=10) covers the mid-frame code switch of the
// unsynchronised build. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_gray_pdm_fb;

    logic       clk;
    logic       rst;
    logic       en4, cv4, cr4, pdm4, fs4;
    logic [3:0] ci4;
    logic       en10, cv10, cr10, pdm10, fs10;
    logic [9:0] ci10;

    int          total = 0;
    int          bad   = 0;
    int          ones;
    int          n;
    logic [15:0] pat;

    gray_pdm_fb #(.WIDTH(4)) u4 (
        .clk_ext     (clk),
        .rst_ext     (rst),
        .en          (en4),
        .code_in     (ci4),
        .code_valid  (cv4),
        .code_ready  (cr4),
        .pdm_out     (pdm4),
        .frame_start (fs4)
    );

    gray_pdm_fb #(.WIDTH(10)) u10 (
        .clk_ext     (clk),
        .rst_ext     (rst),
        .en          (en10),
        .code_in     (ci10),
        .code_valid  (cv10),
        .code_ready  (cr10),
        .pdm_out     (pdm10),
        .frame_start (fs10)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a code to u4 until it is accepted (bounded).
    task automatic load4(input logic [3:0] c);
        logic acc;
        int   k;
        cv4 = 1'b1;
        ci4 = c;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 64) begin
            acc = cr4;
            step();
            k++;
        end
        cv4 = 1'b0;
        if (!acc) chk("load_timeout", 32'd0, 32'd1);
    endtask

    // Find the next frame_start on u4 and count ones over that frame.
    task automatic measure4(input bit skip, output int o, output logic [15:0] p);
        int k;
        o = 0;
        p = '0;
        k = 0;
        if (skip) step();
        while (fs4 !== 1'b1 && k < 64) begin
            step();
            k++;
        end
        if (fs4 !== 1'b1) begin
            o = -1;
            return;
        end
        for (int i = 0; i < 16; i++) begin
            p[i] = pdm4;
            o += int'(pdm4);
            step();
        end
    endtask

    initial begin
        rst  = 1'b1;
        en4  = 1'b0; cv4  = 1'b0; ci4  = 4'd0;
        en10 = 1'b0; cv10 = 1'b0; ci10 = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pdm", {31'd0, pdm4}, 32'd0);
        chk("rst_fs", {31'd0, fs4}, 32'd0);
        chk("rst_ready", {31'd0, cr4}, 32'd1);
        chk("rst_pdm10", {31'd0, pdm10}, 32'd0);

        // First enabled edge after release starts a frame
        rst = 1'b0;
        en4 = 1'b1;
        step();
        chk("first_fs", {31'd0, fs4}, 32'd1);

        // Density sweep with bit-pattern spot checks
        for (int c = 0; c < 16; c++) begin
            load4(4'(c));
            measure4(1'b1, ones, pat);
            chk($sformatf("density_c%0d", c), ones, c);
            if (c == 8)  chk("pattern_c8", {16'd0, pat}, 32'h0000_5555);
            if (c == 15) chk("pattern_c15", {16'd0, pat}, 32'h0000_7FFF);
            if (c == 1)  chk("pattern_c1", {16'd0, pat}, 32'h0000_0080);
            if (c == 10) chk("pattern_c10", {16'd0, pat}, 32'h0000_5D5D);
        end

        // Enable freeze for 5 cycles after cnt=5
        load4(4'd6);
        step();
        n = 0;
        while (fs4 !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        chk("freeze_fs_found", {31'd0, fs4}, 32'd1);
        ones = 0;
        for (int i = 0; i < 6; i++) begin
            ones += int'(pdm4);
            if (i < 5) step();
        end
        en4 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("freeze_pdm", {31'd0, pdm4}, 32'd0);
            chk("freeze_fs", {31'd0, fs4}, 32'd0);
        end
        en4 = 1'b1;
        for (int i = 6; i < 16; i++) begin
            step();
            ones += int'(pdm4);
        end
        chk("freeze_total", ones, 6);
        step();
        chk("freeze_wrap_fs", {31'd0, fs4}, 32'd1);

        // Asynchronous reset mid-cycle, with a code possibly pending
        load4(4'd15);
        measure4(1'b1, ones, pat);
        load4(4'd9);
        step();
        chk("pre_rst_pdm", {31'd0, pdm4}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_pdm", {31'd0, pdm4}, 32'd0);
        chk("async_rst_fs", {31'd0, fs4}, 32'd0);
        chk("async_rst_ready", {31'd0, cr4}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_fs", {31'd0, fs4}, 32'd1);
        measure4(1'b0, ones, pat);
        chk("post_rst_density", ones, 0);

`ifdef GRAY_PDM_FRAME_SYNC_EN
        // Handshake: code 3 accepted mid-frame, second code 7 stalls
        load4(4'd10);
        measure4(1'b1, ones, pat);
        chk("hs_base_density", ones, 10);
        chk("hs_fs", {31'd0, fs4}, 32'd1);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            ones += int'(pdm4);
            if (i == 4) begin
                cv4 = 1'b1;
                ci4 = 4'd3;
                chk("hs_ready_before", {31'd0, cr4}, 32'd1);
            end
            if (i == 5) begin
                chk("hs_ready_fall", {31'd0, cr4}, 32'd0);
                ci4 = 4'd7;
            end
            if (i == 15) chk("hs_ready_return", {31'd0, cr4}, 32'd1);
            step();
        end
        chk("hs_second_accepted", {31'd0, cr4}, 32'd0);
        cv4 = 1'b0;
        chk("hs_old_density", ones, 10);
        measure4(1'b0, ones, pat);
        chk("hs_new_density", ones, 3);
        measure4(1'b0, ones, pat);
        chk("hs_second_density", ones, 7);

        // Bypass: code 12 accepted exactly on the frame-end edge
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            ones += int'(pdm4);
            if (i == 14) begin
                cv4 = 1'b1;
                ci4 = 4'd12;
                chk("bp_ready", {31'd0, cr4}, 32'd1);
            end
            if (i == 15) begin
                chk("bp_no_pend", {31'd0, cr4}, 32'd1);
                cv4 = 1'b0;
            end
            step();
        end
        chk("bp_cur_density", ones, 7);
        measure4(1'b0, ones, pat);
        chk("bp_new_density", ones, 12);
`else
        // Unsynchronised: ready tied high, switch 0 -> 1023 at cnt=512
        cv4 = 1'b1;
        chk("unsync_ready", {31'd0, cr4}, 32'd1);
        cv4 = 1'b0;
        en10 = 1'b1;
        n = 0;
        step();
        while (fs10 !== 1'b1 && n < 1100) begin
            step();
            n++;
        end
        chk("w10_fs_found", {31'd0, fs10}, 32'd1);
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            ones += int'(pdm10);
            if (i == 510) begin
                cv10 = 1'b1;
                ci10 = 10'd1023;
            end
            if (i == 511) cv10 = 1'b0;
            step();
        end
        chk("w10_mixed_frame", ones, 511);
        chk("w10_next_fs", {31'd0, fs10}, 32'd1);
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            ones += int'(pdm10);
            step();
        end
        chk("w10_full_frame", ones, 1023);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
